// File: rtl/counting_scheduler_pkg.sv
// Shared encodings, widths and the token-detector transition rule for the
// counting scheduler and its sequence-match core.
package counting_scheduler_pkg;

    // Field widths of the request/response interface
    localparam int LEN_W = 4;
    localparam int CNT_W = 4;
    localparam int ID_W  = 2;

    // Match counter saturates instead of wrapping
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // 2-bit token alphabet
    typedef enum logic [1:0] {
        TOK_NONE = 2'd0,
        TOK_1    = 2'd1,
        TOK_2    = 2'd2,
        TOK_3    = 2'd3
    } token_t;

    // Detector progress through the 1-2-3 pattern
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    // Scheduler top-level phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        RESP   = 2'd2
    } sched_state_t;

    // Next detector state for one consumed token. A '1' always restarts the
    // pattern, so a repeated '1' keeps the detector armed in S1.
    function automatic det_state_t det_next(input det_state_t s, input logic [1:0] t);
        det_state_t n;
        n = S0;
        case (t)
            TOK_1:   n = S1;
            TOK_2:   n = (s == S1) ? S2 : S0;
            TOK_3:   n = (s == S2) ? S3 : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/counting_scheduler_seq_match_core.sv
// Single 1-2-3 token sequence detector. Consumes at most one token per cycle
// and emits a registered one-cycle hit whenever the pattern completes.
module seq_match_core
    import counting_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       token_valid,
    input  logic [1:0] token,
    output logic       hit
);

    det_state_t r_state;
    det_state_t w_state_next;
    logic       r_hit;

    assign w_state_next = det_next(r_state, token);
    assign hit          = r_hit;

    // Advance the detector on each valid token; clear forces a fresh start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S0;
            r_hit   <= 1'b0;
        end else if (clear) begin
            r_state <= S0;
            r_hit   <= 1'b0;
        end else if (token_valid) begin
            r_state <= w_state_next;
            r_hit   <= (w_state_next == S3);
        end else begin
            r_hit   <= 1'b0;
        end
    end

endmodule

// File: rtl/counting_scheduler.sv
// Round-robin scheduler sharing one 1-2-3 detector between N_REQ requesters.
// A granted burst is captured, streamed into the detector one token per cycle,
// and the number of completed matches is returned over a valid/ready port.
module counting_scheduler
    import counting_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*2*MAX_LEN-1:0] req_tokens,
    input  logic [N_REQ*LEN_W-1:0]     req_len,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [CNT_W-1:0]           resp_count
);

    localparam int TOK_W = 2 * MAX_LEN;

    // Requester 0 gets first pick after reset because the search starts at last+1
    localparam logic [ID_W-1:0] LAST_GRANT_RST = ID_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    sched_state_t       r_state;
    logic [N_REQ-1:0]   r_req_ready;
    logic               r_resp_valid;
    logic [ID_W-1:0]    r_resp_id;
    logic [CNT_W-1:0]   r_resp_count;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_id;
    logic [TOK_W-1:0]   r_tokens;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_count;

    // ------------------------------------------------------------------
    // Per-requester views of the packed request buses, length pre-clamped
    // ------------------------------------------------------------------
    logic [TOK_W-1:0]   w_tok_arr [N_REQ];
    logic [LEN_W-1:0]   w_len_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            logic [LEN_W-1:0] w_len_raw;
            assign w_len_raw     = req_len[gi*LEN_W +: LEN_W];
            assign w_tok_arr[gi] = req_tokens[gi*TOK_W +: TOK_W];
            assign w_len_arr[gi] = (w_len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_len_raw;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: first pending requester after the last one served
    // ------------------------------------------------------------------
    logic              w_found;
    logic [ID_W-1:0]   w_grant_id;
    logic [ID_W-1:0]   w_cand;

    // Walk the requesters starting just past the previous grant, with wrap
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_cand     = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = ID_W'((int'(r_last_grant) + off) % N_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found    = 1'b1;
                w_grant_id = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Detector feed. The detector is held cleared outside STREAM so every
    // burst starts from S0 without needing an explicit clear pulse.
    // ------------------------------------------------------------------
    logic [TOK_W-1:0]  w_tok_shift;
    logic [1:0]        w_token;
    logic              w_tok_valid;
    logic              w_det_clear;
    logic              w_hit;
    logic [CNT_W-1:0]  w_count_next;

    assign w_tok_shift = r_tokens >> {r_idx, 1'b0};
    assign w_token     = w_tok_shift[1:0];
    assign w_tok_valid = (r_state == STREAM) && (r_idx < r_len);
    assign w_det_clear = (r_state != STREAM);

    // The hit of the last token lands one cycle after it is fed, so the
    // final count is taken from here when STREAM hands over to RESP
    assign w_count_next = (w_hit && (r_count != CNT_MAX)) ? r_count + CNT_W'(1) : r_count;

    seq_match_core u_core (
        .clk         (clk),
        .reset       (reset),
        .clear       (w_det_clear),
        .token_valid (w_tok_valid),
        .token       (w_token),
        .hit         (w_hit)
    );

    // ------------------------------------------------------------------
    // Scheduler FSM with registered handshake outputs
    // ------------------------------------------------------------------
    // Grant, stream, then hold the result until the consumer takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_ready  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_count <= '0;
            r_last_grant <= LAST_GRANT_RST;
            r_id         <= '0;
            r_tokens     <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= '0;
                    if (w_found) begin
                        r_req_ready <= N_REQ'(1) << w_grant_id;
                        r_id        <= w_grant_id;
                        r_tokens    <= w_tok_arr[w_grant_id];
                        r_len       <= w_len_arr[w_grant_id];
                        r_idx       <= '0;
                        r_count     <= '0;
                        r_state     <= STREAM;
                    end
                end

                STREAM: begin
                    r_req_ready <= '0;
                    r_count     <= w_count_next;
                    if (r_idx < r_len) begin
                        r_idx <= r_idx + LEN_W'(1);
                    end else begin
                        // All tokens fed (or none at all): publish the result
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_id;
                        r_resp_count <= w_count_next;
                        r_state      <= RESP;
                    end
                end

                RESP: begin
                    r_req_ready <= '0;
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_last_grant <= r_id;
                        r_state      <= IDLE;
                    end
                end

                default: begin
                    r_req_ready  <= '0;
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_count = r_resp_count;

endmodule

// File: tb/tb_counting_scheduler.sv
// Directed and randomized bench for counting_scheduler. Expected grants come
// from a round-robin pick over the request mask and expected counts from
// counting literal 1,2,3 substrings in the captured burst.
module tb_counting_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_tokens;
    logic [15:0] req_len;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [3:0]  resp_count;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int last_g = 3;

    counting_scheduler #(.N_REQ(4), .MAX_LEN(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tokens (req_tokens),
        .req_len    (req_len),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_count (resp_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int t0, input int t1, input int t2, input int t3,
                                       input int t4, input int t5, input int t6, input int t7);
        return {2'(t7), 2'(t6), 2'(t5), 2'(t4), 2'(t3), 2'(t2), 2'(t1), 2'(t0)};
    endfunction

    // Number of positions where the tokens read ...1,2,3 within the clamped burst
    function automatic int model_count(input logic [15:0] t, input int len);
        int l;
        int c;
        l = (len > 8) ? 8 : len;
        c = 0;
        for (int k = 2; k < l; k++) begin
            if (t[2*(k-2) +: 2] == 2'd1 && t[2*(k-1) +: 2] == 2'd2 && t[2*k +: 2] == 2'd3)
                c++;
        end
        return c;
    endfunction

    function automatic int rr_pick(input logic [3:0] m, input int last);
        for (int off = 1; off <= 4; off++) begin
            if (m[(last + off) % 4]) return (last + off) % 4;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [15:0] tk, input int len);
        req_tokens[i*16 +: 16] = tk;
        req_len[i*4 +: 4]      = 4'(len);
    endtask

    // One full grant/stream/response round against the reference model
    task automatic transact(input logic [3:0] mask, input bit keep, input int stall);
        int g, t0, w, ln, len_c, exp_cnt;
        logic [15:0] tk;
        req_valid  = mask;
        resp_ready = (stall == 0);
        g = rr_pick(mask, last_g);
        w = 0;
        @(negedge clk);
        while (req_ready == 4'd0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("grant_seen", 32'(req_ready != 4'd0), 1);
        if (req_ready == 4'd0) return;
        check("grant_onehot", 32'(req_ready), 32'(4'd1 << g));
        t0      = cyc;
        tk      = req_tokens[g*16 +: 16];
        ln      = int'(req_len[g*4 +: 4]);
        len_c   = (ln > 8) ? 8 : ln;
        exp_cnt = model_count(tk, ln);
        // Requester inputs change right after the grant; the DUT must have captured them
        if (!keep) req_valid[g] = 1'b0;
        req_tokens[g*16 +: 16] = 16'($urandom);
        req_len[g*4 +: 4]      = keep ? 4'd3 : 4'($urandom);
        w = 0;
        @(negedge clk);
        check("grant_pulse", 32'(req_ready), 0);
        while (!resp_valid && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("resp_seen", 32'(resp_valid), 1);
        if (!resp_valid) return;
        check("latency", cyc - t0, (len_c == 0) ? 1 : len_c + 1);
        check("resp_id", 32'(resp_id), g);
        check("resp_count", 32'(resp_count), exp_cnt);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 1);
            check("hold_id", 32'(resp_id), g);
            check("hold_count", 32'(resp_count), exp_cnt);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("resp_drop", 32'(resp_valid), 0);
        last_g = g;
        $display("txn mask=%b grant=%0d len=%0d count=%0d stall=%0d", mask, g, ln, exp_cnt, stall);
    endtask

    initial begin
        int w;
        reset      = 1'b1;
        req_valid  = '0;
        req_tokens = '0;
        req_len    = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_id", 32'(resp_id), 0);
        check("rst_resp_count", 32'(resp_count), 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed bursts from the test plan
        set_req(0, mk(1,2,3,0,0,0,0,0), 3);
        transact(4'b0001, 1'b0, 0);
        set_req(1, mk(1,2,3,1,2,3,0,0), 6);
        transact(4'b0010, 1'b0, 0);
        set_req(1, mk(1,2,0,3,3,1,2,2), 8);
        transact(4'b0010, 1'b0, 0);
        set_req(2, mk(1,1,2,1,2,3,0,0), 6);
        transact(4'b0100, 1'b0, 0);
        set_req(3, mk(1,2,3,1,2,3,1,2), 0);
        transact(4'b1000, 1'b0, 5);

        // All requesters held valid: strict rotation 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_req(i, 16'($urandom), 3);
        for (int n = 0; n < 5; n++) transact(4'b1111, 1'b1, 0);

        // Randomized masks, bursts (including over-long lengths) and stalls
        for (int n = 0; n < 30; n++) begin
            logic [3:0] m;
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) set_req(i, 16'($urandom), int'($urandom_range(0, 15)));
            transact(m, 1'b0, int'($urandom_range(0, 2)));
        end
        req_valid = '0;
        @(negedge clk);

        // Reset in the middle of a long burst aborts it without a response
        set_req(0, 16'($urandom), 8);
        req_valid = 4'b0001;
        w = 0;
        @(negedge clk);
        while (req_ready == 4'd0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("abort_grant", 32'(req_ready), 1);
        req_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_req_ready", 32'(req_ready), 0);
        check("abort_resp_valid", 32'(resp_valid), 0);
        check("abort_resp_id", 32'(resp_id), 0);
        check("abort_resp_count", 32'(resp_count), 0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        last_g = 3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid), 0);
        end
        set_req(0, 16'($urandom), int'($urandom_range(0, 8)));
        set_req(1, 16'($urandom), int'($urandom_range(0, 8)));
        transact(4'b0011, 1'b0, 0);
        req_valid = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
